saradc_sar_ctrl: RTL and testbench
==================================

SARADC_SAR_CTRL -- requirements
Module: saradc_sar_ctrl

Interface
REQ-001 Parameter NBITS, default 8, sets the conversion resolution and the width of the DAC and result buses; legal range 4..14.
REQ-002 Parameter SAMPLE_CYCLES, default 2, sets the number of clk cycles the sample switch is held closed; legal range 1..15.
REQ-003 Port clk, input, 1, the single block clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, requests a conversion; sampled only in IDLE.
REQ-006 Port cmp_out, input, 1, latched comparator decision (1 = input above DAC level); valid at the end of any cycle where cmp_en=1.
REQ-007 Port sample_en, output, 1, drives the analog sample-switch inverter cell.
REQ-008 Port dac_p, output, NBITS, per-bit drive to the capacitor-array driver cells; MSB is the largest capacitor.
REQ-009 Port cmp_en, output, 1, comparator strobe.
REQ-010 Port result, output, NBITS, last completed conversion code.
REQ-011 Port result_valid, output, 1, result available (valid/ready source).
REQ-012 Port result_ready, input, 1, downstream accepts result.
REQ-013 Port busy, output, 1, high in every state except IDLE.

Function
REQ-014 FSM states are IDLE, SAMPLE, SETTLE, COMPARE and DONE.
REQ-015 In IDLE with start=1, the FSM shall enter SAMPLE next cycle, clear the trial register and set the bit index to NBITS-1.
REQ-016 SAMPLE shall assert sample_en for exactly SAMPLE_CYCLES cycles with dac_p=0, then enter SETTLE.
REQ-017 SETTLE (1 cycle) shall drive dac_p = trial code with the current bit forced to 1, with cmp_en=0.
REQ-018 COMPARE (1 cycle) shall hold the same dac_p with cmp_en=1; at its end the current bit shall be kept if cmp_out=1 and cleared otherwise.
REQ-019 After COMPARE of bit 0 the FSM shall enter DONE, load result with the final code and assert result_valid; otherwise it shall decrement the bit index and return to SETTLE.
REQ-020 Latency from start accepted to result_valid=1 shall be exactly SAMPLE_CYCLES + 2*NBITS + 1 cycles.
REQ-021 In DONE, result_valid shall stay high and result stable until result_valid & result_ready; the FSM then returns to IDLE with result_valid=0 and result retained.
REQ-022 start shall be ignored in all states except IDLE, including DONE with a pending result.
REQ-023 sample_en and cmp_en shall never be high in the same cycle; dac_p shall be 0 in IDLE, SAMPLE and DONE.
REQ-024 All outputs shall be registered, with no combinational path from any input to any output.

Reset
REQ-025 On rst_n=0, mid-conversion included, the FSM shall return to IDLE and all outputs shall go to 0 (sample_en, cmp_en, dac_p, result, result_valid, busy) asynchronously; the first start is accepted on the first clk edge after release.

Configuration
REQ-026 With macro SARADC_SAR_CTRL_CONT_EN defined, an extra input cont (1 bit) shall exist; when cont=1, DONE shall go directly to SAMPLE on the handshake, with no IDLE cycle.
REQ-027 Without SARADC_SAR_CTRL_CONT_EN, port cont shall not exist and DONE shall always return to IDLE.

Structure
REQ-028 State encoding enum and default-parameter constants shall live in the shared package saradc_pkg.
REQ-029 The sample-phase counter shall be a sub-module saradc_cnt (loadable down-counter with a zero flag); all other logic shall be flat.

Verification
REQ-030 NBITS=8, SAMPLE_CYCLES=2, cmp_out modelled as (vin > dac_p) with vin=0xA5, ready=1 -> result=0xA5, result_valid at cycle 19 after start.
REQ-031 cmp_out stuck 1 -> result=0xFF; cmp_out stuck 0 -> result=0x00; each trial dac_p pattern checked per COMPARE cycle.
REQ-032 result_ready=0 for 5 cycles in DONE, with start pulsed -> result held, no new conversion, busy=1; ready=1 -> IDLE.
REQ-033 rst_n pulsed low during SETTLE of bit 4 -> all outputs 0 immediately; a new conversion after release completes correctly.
REQ-034 With SARADC_SAR_CTRL_CONT_EN and cont=1, three back-to-back conversions (vin 0x00, 0x80, 0xFF) -> sample_en rises the cycle after each handshake.
REQ-035 Assertion over all tests: sample_en & cmp_en is never 1.

Source files
------------

// File: rtl/saradc_pkg.sv
// Shared SAR ADC controller definitions: FSM state encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package saradc_pkg;

    localparam int unsigned SARADC_NBITS_DEF         = 8;
    localparam int unsigned SARADC_SAMPLE_CYCLES_DEF = 2;
    // Wide enough for the largest legal sample window (15 cycles).
    localparam int unsigned SARADC_CNT_W             = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } sar_state_e;

endpackage

// File: rtl/saradc_sar_ctrl_if.sv
// Controller-side bus of the SAR ADC: start/result handshake plus analog drive/sense.
// Latency: n/a (wiring only).
// Backpressure: result_valid/result_ready handshake; optional cont with SARADC_SAR_CTRL_CONT_EN.
interface saradc_sar_ctrl_if #(
    parameter int unsigned NBITS = saradc_pkg::SARADC_NBITS_DEF
);
    logic             start;
    logic             cmp_out;
    logic             sample_en;
    logic [NBITS-1:0] dac_p;
    logic             cmp_en;
    logic [NBITS-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

`ifdef SARADC_SAR_CTRL_CONT_EN
    logic             cont;

    modport master (
        input  start, cmp_out, result_ready, cont,
        output sample_en, dac_p, cmp_en, result, result_valid, busy
    );
    modport slave (
        output start, cmp_out, result_ready, cont,
        input  sample_en, dac_p, cmp_en, result, result_valid, busy
    );
`else
    modport master (
        input  start, cmp_out, result_ready,
        output sample_en, dac_p, cmp_en, result, result_valid, busy
    );
    modport slave (
        output start, cmp_out, result_ready,
        input  sample_en, dac_p, cmp_en, result, result_valid, busy
    );
`endif

endinterface

// File: rtl/saradc_cnt.sv
// Loadable down-counter with zero flag, used to time the sample window.
// Latency: load/decrement take effect on the next clk edge; zero flag follows the register.
// Backpressure: none; decrement saturates at zero.
module saradc_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    // Load has priority over decrement; never wrap below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/saradc_sar_ctrl.sv
// SAR ADC controller: sample, then one SETTLE/COMPARE pair per bit from MSB to LSB.
// Latency: SAMPLE_CYCLES + 2*NBITS + 1 cycles from start accepted (start cycle counted) to result_valid.
// Backpressure: result held in DONE until result_ready; start ignored outside IDLE.
// Optional macro SARADC_SAR_CTRL_CONT_EN adds bus.cont: DONE goes straight to SAMPLE on handshake.
module saradc_sar_ctrl
    import saradc_pkg::*;
#(
    parameter int unsigned NBITS         = SARADC_NBITS_DEF,
    parameter int unsigned SAMPLE_CYCLES = SARADC_SAMPLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    saradc_sar_ctrl_if.master bus
);
    localparam int unsigned              IDX_W    = $clog2(NBITS);
    localparam logic [IDX_W-1:0]         IDX_MSB  = IDX_W'(NBITS - 1);
    localparam logic [SARADC_CNT_W-1:0]  CNT_LOAD = SARADC_CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [NBITS-1:0]         ONE      = NBITS'(1);

    sar_state_e       r_state, w_state_nxt;
    logic [NBITS-1:0] r_trial, w_trial_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [NBITS-1:0] r_result, w_result_nxt;
    logic [NBITS-1:0] w_bit_cur, w_bit_nxt;

    logic             r_sample_en, w_sample_en_nxt;
    logic             r_cmp_en, w_cmp_en_nxt;
    logic [NBITS-1:0] r_dac, w_dac_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy, w_busy_nxt;

    logic             w_restart;
    logic             w_begin;
    logic             w_cnt_dec;
    logic             w_cnt_zero;

`ifdef SARADC_SAR_CTRL_CONT_EN
    assign w_restart = bus.cont;
`else
    assign w_restart = 1'b0;
`endif

    // A new conversion launches on this edge (from IDLE, or directly from DONE in continuous mode).
    assign w_begin   = (w_state_nxt == ST_SAMPLE) && (r_state != ST_SAMPLE);
    assign w_cnt_dec = (r_state == ST_SAMPLE) && !w_cnt_zero;
    assign w_bit_cur = ONE << r_idx;
    assign w_bit_nxt = ONE << w_idx_nxt;

    saradc_cnt #(
        .W (SARADC_CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_begin),
        .i_load_val (CNT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:    if (bus.start) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE:  if (w_cnt_zero) w_state_nxt = ST_SETTLE;
            ST_SETTLE:  w_state_nxt = ST_COMPARE;
            ST_COMPARE: w_state_nxt = (r_idx == '0) ? ST_DONE : ST_SETTLE;
            ST_DONE:    if (bus.result_ready) w_state_nxt = w_restart ? ST_SAMPLE : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Successive-approximation datapath: the trial register holds only decided bits.
    always_comb begin
        w_trial_nxt  = r_trial;
        w_idx_nxt    = r_idx;
        w_result_nxt = r_result;
        if (w_begin) begin
            w_trial_nxt = '0;
            w_idx_nxt   = IDX_MSB;
        end else if (r_state == ST_COMPARE) begin
            if (bus.cmp_out) begin
                w_trial_nxt = r_trial | w_bit_cur;
            end
            if (r_idx == '0) begin
                w_result_nxt = w_trial_nxt;
            end else begin
                w_idx_nxt = r_idx - IDX_W'(1);
            end
        end
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        w_sample_en_nxt = 1'b0;
        w_cmp_en_nxt    = 1'b0;
        w_dac_nxt       = '0;
        w_valid_nxt     = 1'b0;
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        unique case (w_state_nxt)
            ST_SAMPLE:  w_sample_en_nxt = 1'b1;
            ST_SETTLE:  w_dac_nxt       = w_trial_nxt | w_bit_nxt;
            ST_COMPARE: begin
                w_dac_nxt    = w_trial_nxt | w_bit_nxt;
                w_cmp_en_nxt = 1'b1;
            end
            ST_DONE:    w_valid_nxt     = 1'b1;
            default:    ;
        endcase
    end

    // Datapath and output registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trial     <= '0;
            r_idx       <= '0;
            r_result    <= '0;
            r_sample_en <= 1'b0;
            r_cmp_en    <= 1'b0;
            r_dac       <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_trial     <= w_trial_nxt;
            r_idx       <= w_idx_nxt;
            r_result    <= w_result_nxt;
            r_sample_en <= w_sample_en_nxt;
            r_cmp_en    <= w_cmp_en_nxt;
            r_dac       <= w_dac_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.sample_en    = r_sample_en;
    assign bus.cmp_en       = r_cmp_en;
    assign bus.dac_p        = r_dac;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Self-checking bench for saradc_sar_ctrl (NBITS=8, SAMPLE_CYCLES=2).
// Latency: checks start-to-valid count, trial DAC codes, handshake, reset and exclusivity.
// Backpressure: holds result_ready low in DONE; continuous mode exercised with SARADC_SAR_CTRL_CONT_EN.
module tb_saradc_sar_ctrl;

    logic clk;
    logic rst_n;

    saradc_sar_ctrl_if #(.NBITS(8)) bus ();

    saradc_sar_ctrl #(
        .NBITS         (8),
        .SAMPLE_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] vin     = 8'h00;
    int         cmp_mode = 0;   // 0: analog model, 1: stuck high, 2: stuck low
    logic [7:0] exp_q[$];

    // Analog input sits half an LSB above code vin, so a strict vin > dac_p comparison converges to vin.
    assign bus.cmp_out = (cmp_mode == 1) ? 1'b1 :
                         (cmp_mode == 2) ? 1'b0 :
                         ({vin, 1'b1} > {bus.dac_p, 1'b0});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample and comparator strobes must never overlap.
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            assert (!(bus.sample_en && bus.cmp_en)) else begin
                n_fail++;
                $error("FAIL excl: observed sample_en=%0b cmp_en=%0b expected not both", bus.sample_en, bus.cmp_en);
            end
        end
    end

    // Runs one conversion up to result_valid, checking every sample and compare cycle.
    task automatic convert(input logic [7:0] exp_code, input logic [7:0] v, input int mode, input bit do_start);
        int         cyc;
        int         bitn;
        int         n_smp;
        int         n_cmp;
        logic [7:0] m;
        logic [7:0] exp_dac;
        vin      = v;
        cmp_mode = mode;
        exp_q.push_back(exp_code);
        if (do_start) begin
            @(negedge clk);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        cyc   = 1;
        bitn  = 7;
        n_smp = 0;
        n_cmp = 0;
        check("busy_first", 16'(bus.busy), 16'd1);
        while (bus.result_valid !== 1'b1 && cyc < 40) begin
            if (bus.sample_en) begin
                n_smp++;
                check("dac_sample", 16'(bus.dac_p), 16'd0);
            end
            if (bus.cmp_en) begin
                m       = 8'd2 << bitn;
                m       = m - 8'd1;
                exp_dac = (exp_code & ~m) | (8'd1 << bitn);
                check("dac_compare", 16'(bus.dac_p), 16'(exp_dac));
                bitn--;
                n_cmp++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 16'(cyc), 16'd19);
        check("sample_cycles", 16'(n_smp), 16'd2);
        check("compare_cycles", 16'(n_cmp), 16'd8);
        check("dac_done", 16'(bus.dac_p), 16'd0);
    endtask

    // Completes the handshake and checks the state the cycle after it.
    task automatic accept(input bit exp_cont);
        logic [7:0] e;
        bus.result_ready = 1'b1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected one entry");
            e = 8'h00;
        end else begin
            e = exp_q.pop_front();
        end
        check("result", 16'(bus.result), 16'(e));
        check("valid_pending", 16'(bus.result_valid), 16'd1);
        @(posedge clk);
        #1;
        check("valid_cleared", 16'(bus.result_valid), 16'd0);
        check("result_kept", 16'(bus.result), 16'(e));
        check("busy_after", 16'(bus.busy), 16'(exp_cont));
        check("sample_after", 16'(bus.sample_en), 16'(exp_cont));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sample_en"}, 16'(bus.sample_en), 16'd0);
        check({tag, "_cmp_en"}, 16'(bus.cmp_en), 16'd0);
        check({tag, "_dac_p"}, 16'(bus.dac_p), 16'd0);
        check({tag, "_result"}, 16'(bus.result), 16'd0);
        check({tag, "_valid"}, 16'(bus.result_valid), 16'd0);
        check({tag, "_busy"}, 16'(bus.busy), 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] m;
        logic [7:0] exp_dac;
        rst_n            = 1'b1;
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
`ifdef SARADC_SAR_CTRL_CONT_EN
        bus.cont         = 1'b0;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 16'(bus.busy), 16'd0);
        check("idle_sample", 16'(bus.sample_en), 16'd0);

        // Nominal conversion of 0xA5 with ready held high.
        bus.result_ready = 1'b1;
        convert(8'hA5, 8'hA5, 0, 1'b1);
        accept(1'b0);

        // Stuck comparator: all bits kept, then all bits cleared.
        convert(8'hFF, 8'h00, 1, 1'b1);
        accept(1'b0);
        convert(8'h00, 8'h00, 2, 1'b1);
        accept(1'b0);

        // Backpressure in DONE with start pulsed: result held, no restart.
        bus.result_ready = 1'b0;
        convert(8'h3C, 8'h3C, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 1 || i == 2);
            @(posedge clk);
            #1;
            check("bp_valid", 16'(bus.result_valid), 16'd1);
            check("bp_result", 16'(bus.result), 16'h003C);
            check("bp_busy", 16'(bus.busy), 16'd1);
            check("bp_sample", 16'(bus.sample_en), 16'd0);
        end
        bus.start = 1'b0;
        accept(1'b0);

        // Reset during SETTLE of bit 4, then a clean conversion right after release.
        vin      = 8'h5A;
        cmp_mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        m       = 8'h1F;
        exp_dac = (8'h5A & ~m) | 8'h10;
        check("settle4_dac", 16'(bus.dac_p), 16'(exp_dac));
        check("settle4_cmp_en", 16'(bus.cmp_en), 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        check("reset_hold_busy", 16'(bus.busy), 16'd0);
        rst_n = 1'b1;
        convert(8'h5A, 8'h5A, 0, 1'b1);
        accept(1'b0);

`ifdef SARADC_SAR_CTRL_CONT_EN
        // Continuous mode: three back-to-back conversions with no IDLE gap.
        bus.cont = 1'b1;
        convert(8'h00, 8'h00, 0, 1'b1);
        accept(1'b1);
        convert(8'h80, 8'h80, 0, 1'b0);
        accept(1'b1);
        convert(8'hFF, 8'hFF, 0, 1'b0);
        bus.cont = 1'b0;
        accept(1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
